mem_arbiter: RTL and testbench

//  Arbitrates the ACE core's instruction-fetch port (read-only) and data port (read/write) onto the

---
 rtl/ace_mem_pkg.sv | 29 ++
 rtl/mem_rr_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_mem_pkg.sv
// Shared definitions for the ACE memory arbiter: FSM state encoding, port ids,
// the default error read-back word and the address legality rule.
// No ports (package).
package ace_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // An access is legal when it is halfword aligned and every bit at or above
  // limit_bits is zero (the SRAM behind io_ctrl only decodes the low bits).
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned limit_bits);
    logic [31:0] w_hi;
    w_hi = addr >> limit_bits;
    return (addr[0] == 1'b0) && (w_hi == 32'd0);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker between the fetch and data ports.
// Ports: i_fetch_req, i_data_req (request levels), i_last_grant (port id of the
//        previous grant) -> o_grant (port id to serve), o_vld (any request present).
module mem_rr_pick
  import ace_mem_pkg::*;
(
  input  logic i_fetch_req,
  input  logic i_data_req,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_vld
);

  always_comb begin
    o_vld   = i_fetch_req | i_data_req;
    o_grant = PORT_FETCH;
    if (i_fetch_req && i_data_req) begin
      // Tie: the port that did not win last time goes first.
      o_grant = (i_last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    end else if (i_data_req) begin
      o_grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (read-only) and data (read/write) ports of the core onto
// the single strobe/ack memory bus of io_ctrl, with address checking and a
// timeout that recovers from a stalled SRAM controller.
// Ports: clk/reset; fetch port i_req/i_addr -> i_ack/i_rdata/i_err;
//        data port d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata/d_err;
//        memory bus mem_read/mem_write/mem_addr/mem_write_data <- mem_ack/mem_read_data.
// All outputs are registered.
module mem_arbiter
  import ace_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES  = 64,
  parameter int          ADDR_LIMIT_BITS = 20,
  parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // io_ctrl memory bus
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_read_data
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  state_e            w_next_state;

  logic              r_last_grant;
  logic              r_port;
  logic              r_we;
  logic              r_flush;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_i_ack;
  logic [31:0]       r_i_rdata;
  logic              r_i_err;
  logic              r_d_ack;
  logic [31:0]       r_d_rdata;
  logic              r_d_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_pick_vld;
  logic              w_pick_port;
  logic [31:0]       w_req_addr;
  logic [31:0]       w_req_wdata;
  logic              w_req_we;
  logic              w_req_legal;
  logic              w_timeout;

  logic              w_rsp_vld;
  logic              w_rsp_port;
  logic [31:0]       w_rsp_data;
  logic              w_rsp_err;
  logic              w_mem_read_n;
  logic              w_mem_write_n;
  logic [31:0]       w_mem_addr_n;
  logic [31:0]       w_mem_wdata_n;
  logic              w_flush_n;
  logic [CNT_W-1:0]  w_cnt_n;

  mem_rr_pick u_pick (
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_port),
    .o_vld        (w_pick_vld)
  );

  // Request fields of whichever port the picker chose this cycle.
  assign w_req_addr  = (w_pick_port == PORT_DATA) ? d_addr : i_addr;
  assign w_req_we    = (w_pick_port == PORT_DATA) && d_we;
  assign w_req_wdata = w_req_we ? d_wdata : 32'd0;
  assign w_req_legal = addr_legal(w_req_addr, ADDR_LIMIT_BITS);

  // The same counter times both WAIT and FLUSH; it is cleared on entry to each.
  assign w_timeout   = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_vld) w_next_state = w_req_legal ? ST_ISSUE : ST_DONE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (mem_ack || w_timeout) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = r_flush ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: if (mem_ack || w_timeout) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output / datapath next values
  // Everything here is the value the output registers take at the next edge,
  // so a response computed while leaving WAIT is visible during DONE.
  always_comb begin
    w_rsp_vld     = 1'b0;
    w_rsp_port    = r_port;
    w_rsp_data    = 32'd0;
    w_rsp_err     = 1'b0;
    w_mem_read_n  = 1'b0;
    w_mem_write_n = 1'b0;
    w_mem_addr_n  = 32'd0;
    w_mem_wdata_n = 32'd0;
    w_flush_n     = r_flush;
    w_cnt_n       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_flush_n = 1'b0;
          if (w_req_legal) begin
            w_mem_read_n  = ~w_req_we;
            w_mem_write_n = w_req_we;
            w_mem_addr_n  = w_req_addr;
            w_mem_wdata_n = w_req_wdata;
          end else begin
            // Illegal address: answer straight away, never touch the bus.
            w_rsp_vld  = 1'b1;
            w_rsp_port = w_pick_port;
            w_rsp_data = ERR_DATA;
            w_rsp_err  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          w_rsp_vld  = 1'b1;
          w_rsp_data = r_we ? 32'd0 : mem_read_data;
        end else if (w_timeout) begin
          // io_ctrl may still answer later; FLUSH swallows that stale ack.
          w_rsp_vld  = 1'b1;
          w_rsp_data = ERR_DATA;
          w_rsp_err  = 1'b1;
          w_flush_n  = 1'b1;
        end else begin
          w_mem_addr_n  = r_mem_addr;
          w_mem_wdata_n = r_mem_wdata;
          w_cnt_n       = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_cnt_n = '0;
      end
      ST_FLUSH: begin
        if (mem_ack || w_timeout) begin
          w_flush_n = 1'b0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_flush_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= PORT_DATA;
      r_port       <= PORT_FETCH;
      r_we         <= 1'b0;
      r_flush      <= 1'b0;
      r_cnt        <= '0;
      r_i_ack      <= 1'b0;
      r_i_rdata    <= 32'd0;
      r_i_err      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_rdata    <= 32'd0;
      r_d_err      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_vld) begin
        r_port       <= w_pick_port;
        r_last_grant <= w_pick_port;
        r_we         <= w_req_we;
      end
      r_flush     <= w_flush_n;
      r_cnt       <= w_cnt_n;
      r_i_ack     <= w_rsp_vld && (w_rsp_port == PORT_FETCH);
      r_i_rdata   <= (w_rsp_vld && (w_rsp_port == PORT_FETCH)) ? w_rsp_data : 32'd0;
      r_i_err     <= w_rsp_vld && (w_rsp_port == PORT_FETCH) && w_rsp_err;
      r_d_ack     <= w_rsp_vld && (w_rsp_port == PORT_DATA);
      r_d_rdata   <= (w_rsp_vld && (w_rsp_port == PORT_DATA)) ? w_rsp_data : 32'd0;
      r_d_err     <= w_rsp_vld && (w_rsp_port == PORT_DATA) && w_rsp_err;
      r_mem_read  <= w_mem_read_n;
      r_mem_write <= w_mem_write_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
    end
  end

  assign i_ack          = r_i_ack;
  assign i_rdata        = r_i_rdata;
  assign i_err          = r_i_err;
  assign d_ack          = r_d_ack;
  assign d_rdata        = r_d_rdata;
  assign d_err          = r_d_err;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_ack;
  logic [31:0] mem_read_data;

  int n_cmp;
  int n_bad;

  // Environment: io_ctrl latency and SRAM contents seen by the io_ctrl model.
  int          mem_lat;
  logic [31:0] sram [logic [31:0]];
  // Reference model: expected memory contents and round-robin history.
  logic [31:0] ref_mem [logic [31:0]];
  logic        last_g;   // 0 = fetch, 1 = data

  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_ack(mem_ack), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // io_ctrl model: acks mem_lat cycles after the strobe cycle.
  initial begin : io_ctrl_model
    int          cd;
    logic [31:0] pa;
    logic        pw;
    cd = 0; pa = 32'd0; pw = 1'b0;
    mem_ack = 1'b0;
    mem_read_data = 32'd0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_read_data = 32'd0;
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            mem_ack = 1'b1;
            // Garbage on write acks: the arbiter must return 0 for writes.
            mem_read_data = pw ? 32'h5A5A_5A5A : (sram.exists(pa) ? sram[pa] : dflt(pa));
          end
        end
        if (mem_read || mem_write) begin
          cd = mem_lat;
          pa = mem_addr;
          pw = mem_write;
          if (mem_write) sram[mem_addr] = mem_write_data;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // One request on a single port; checks strobe, hold, latency, response.
  task automatic run_single(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input string name);
    logic        legal, tmo, got, er, hold_bad, idle_bad;
    logic [31:0] exp_d, exp_wd, rd;
    logic        exp_e;
    int          exp_c, ack_c, cyc, n_strobe, strobe_c, hold_last;
    legal = (addr < 32'h0010_0000) && (addr % 2 == 0);
    tmo   = legal && (lat > 64);
    exp_wd = we ? wdata : 32'd0;
    if (!legal) begin
      exp_c = 1; exp_d = ERRW; exp_e = 1'b1;
    end else if (tmo) begin
      exp_c = 66; exp_d = ERRW; exp_e = 1'b1;
    end else begin
      exp_c = 2 + lat; exp_e = 1'b0;
      exp_d = we ? 32'd0 : ref_read(addr);
      if (we) ref_mem[addr] = wdata;
    end
    hold_last = tmo ? 65 : 1 + lat;
    last_g = port;
    mem_lat = lat;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    got = 0; er = 0; rd = 32'd0; ack_c = -1; cyc = 0; n_strobe = 0; strobe_c = -1;
    hold_bad = 0; idle_bad = 0;
    while (!got && cyc < 200) begin
      step(); cyc++;
      if (mem_read || mem_write) begin
        n_strobe++; strobe_c = cyc;
        n_cmp++;
        if (mem_read !== !we || mem_write !== we || mem_addr !== addr || mem_write_data !== exp_wd) begin
          n_bad++;
          $display("FAIL %s strobe: rd=%b wr=%b addr=%h wd=%h want rd=%b wr=%b addr=%h wd=%h",
                   name, mem_read, mem_write, mem_addr, mem_write_data, !we, we, addr, exp_wd);
        end
      end
      if (legal && cyc <= hold_last && (mem_addr !== addr || mem_write_data !== exp_wd)) hold_bad = 1;
      if (port ? (i_ack || i_rdata !== 0 || i_err) : (d_ack || d_rdata !== 0 || d_err)) idle_bad = 1;
      if (port ? d_ack : i_ack) begin
        got = 1; ack_c = cyc;
        rd = port ? d_rdata : i_rdata;
        er = port ? d_err : i_err;
        if (port) d_req = 1'b0; else i_req = 1'b0;
      end else if (port ? (d_rdata !== 0 || d_err) : (i_rdata !== 0 || i_err)) begin
        idle_bad = 1;
      end
    end
    n_cmp++;
    if (ack_c != exp_c) begin
      n_bad++; $display("FAIL %s ack_cycle: got %0d want %0d", name, ack_c, exp_c);
    end
    n_cmp++;
    if (rd !== exp_d) begin
      n_bad++; $display("FAIL %s rdata: got %h want %h", name, rd, exp_d);
    end
    n_cmp++;
    if (er !== exp_e) begin
      n_bad++; $display("FAIL %s err: got %b want %b", name, er, exp_e);
    end
    n_cmp++;
    if (n_strobe != (legal ? 1 : 0) || (legal && strobe_c != 1)) begin
      n_bad++; $display("FAIL %s strobes: got %0d at cycle %0d want %0d at cycle 1",
                        name, n_strobe, strobe_c, legal ? 1 : 0);
    end
    n_cmp++;
    if (hold_bad || idle_bad) begin
      n_bad++; $display("FAIL %s hold/quiet: hold_bad=%b idle_bad=%b want 0/0", name, hold_bad, idle_bad);
    end
    step(); cyc++;
    n_cmp++;
    if (i_ack || d_ack || mem_addr !== 32'd0 || mem_write_data !== 32'd0) begin
      n_bad++; $display("FAIL %s after_ack: i_ack=%b d_ack=%b addr=%h wd=%h want all 0",
                        name, i_ack, d_ack, mem_addr, mem_write_data);
    end
    if (tmo) begin
      // Stale ack lands in FLUSH at cycle 1+lat; arbiter idle again at 2+lat.
      idle_bad = 0;
      while (cyc < 2 + lat) begin
        step(); cyc++;
        if (i_ack || d_ack) idle_bad = 1;
      end
      n_cmp++;
      if (idle_bad) begin
        n_bad++; $display("FAIL %s flush_ack: got port ack during flush, want none", name);
      end
    end
  endtask

  // Both ports request in the same cycle.
  task automatic run_pair(input logic [31:0] fa, input logic [31:0] da, input logic dwe,
                          input logic [31:0] dwd, input int lat, input string name);
    int          f, s, cyc;
    int          exp_c [2];
    int          got_c [2];
    logic [31:0] exp_d [2];
    logic [31:0] got_d [2];
    logic        got_e [2];
    f = (last_g == 1'b1) ? 0 : 1;
    s = 1 - f;
    exp_d[0] = ref_read(fa);
    exp_d[1] = dwe ? 32'd0 : ref_read(da);
    if (dwe) ref_mem[da] = dwd;
    exp_c[f] = 2 + lat;
    exp_c[s] = 5 + 2 * lat;
    last_g = (s == 1);
    mem_lat = lat;
    i_req = 1'b1; i_addr = fa;
    d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = dwd;
    got_c[0] = -1; got_c[1] = -1;
    got_d[0] = 32'd0; got_d[1] = 32'd0; got_e[0] = 1'b0; got_e[1] = 1'b0;
    cyc = 0;
    while ((got_c[0] < 0 || got_c[1] < 0) && cyc < 300) begin
      step(); cyc++;
      if (i_ack) begin
        if (got_c[0] < 0) begin got_c[0] = cyc; got_d[0] = i_rdata; got_e[0] = i_err; end
        i_req = 1'b0;
      end
      if (d_ack) begin
        if (got_c[1] < 0) begin got_c[1] = cyc; got_d[1] = d_rdata; got_e[1] = d_err; end
        d_req = 1'b0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      n_cmp++;
      if (got_c[p] != exp_c[p]) begin
        n_bad++; $display("FAIL %s port%0d ack_cycle: got %0d want %0d", name, p, got_c[p], exp_c[p]);
      end
      n_cmp++;
      if (got_d[p] !== exp_d[p] || got_e[p] !== 1'b0) begin
        n_bad++; $display("FAIL %s port%0d data: got %h err %b want %h err 0",
                          name, p, got_d[p], got_e[p], exp_d[p]);
      end
    end
    step();
  endtask

  task automatic test_reset;
    repeat (3) step();
    n_cmp++;
    if ({i_ack, i_err, d_ack, d_err, mem_read, mem_write, i_rdata, d_rdata, mem_addr, mem_write_data} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0",
                        {i_ack, i_err, d_ack, d_err, mem_read, mem_write, i_rdata, d_rdata, mem_addr, mem_write_data});
    end
    reset = 1'b0;
    last_g = 1'b1;
    step(); step();
    n_cmp++;
    if ({i_ack, d_ack, mem_read, mem_write, mem_addr} !== '0) begin
      n_bad++; $display("FAIL idle_outputs: got %h want 0", {i_ack, d_ack, mem_read, mem_write, mem_addr});
    end
  endtask

  task automatic test_tie_order;
    run_pair(32'h300, 32'h204, 1'b0, 32'd0, 2, "tie1");
    run_pair(32'h308, 32'h208, 1'b0, 32'd0, 1, "tie2");
  endtask

  task automatic test_fetch_read;
    sram[32'h10] = 32'h1234_5678;
    ref_mem[32'h10] = 32'h1234_5678;
    run_single(1'b0, 1'b0, 32'h10, 32'd0, 3, "fetch_read");
  endtask

  task automatic test_write;
    run_single(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 2, "data_write");
    run_single(1'b0, 1'b0, 32'h100, 32'd0, 1, "readback");
  endtask

  task automatic test_illegal;
    run_single(1'b1, 1'b0, 32'h11, 32'd0, 2, "odd_addr");
    run_single(1'b1, 1'b0, 32'h0010_0000, 32'd0, 2, "high_addr");
    run_single(1'b0, 1'b0, 32'h000F_FFFE, 32'd0, 2, "top_legal");
  endtask

  task automatic test_timeout;
    run_single(1'b0, 1'b0, 32'h20, 32'd0, 70, "timeout");
    run_single(1'b1, 1'b0, 32'h24, 32'd0, 4, "after_flush");
    run_single(1'b1, 1'b0, 32'h28, 32'd0, 64, "last_wait_ack");
  endtask

  task automatic test_reset_mid;
    mem_lat = 1000;
    i_req = 1'b1; i_addr = 32'h40;
    repeat (5) step();
    n_cmp++;
    if (mem_addr !== 32'h40) begin
      n_bad++; $display("FAIL mid_wait_addr: got %h want %h", mem_addr, 32'h40);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({i_ack, i_err, d_ack, d_err, mem_read, mem_write, i_rdata, d_rdata, mem_addr, mem_write_data} !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0",
                        {i_ack, i_err, d_ack, d_err, mem_read, mem_write, i_rdata, d_rdata, mem_addr, mem_write_data});
    end
    i_req = 1'b0;
    step(); step();
    reset = 1'b0;
    last_g = 1'b1;
    step();
    run_single(1'b0, 1'b0, 32'h44, 32'd0, 2, "post_reset");
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      int          r, lat;
      logic        port, we;
      logic [31:0] a;
      r   = $urandom_range(0, 9);
      lat = $urandom_range(1, 6);
      a   = 32'h200 + 32'($urandom_range(0, 15)) * 4;
      if (r < 2) begin
        run_pair(32'h300 + 32'($urandom_range(0, 15)) * 4, a, 1'($urandom_range(0, 1)),
                 $urandom, lat, "rand_pair");
      end else begin
        port = 1'($urandom_range(0, 1));
        we   = port & 1'($urandom_range(0, 1));
        if (r == 2) a = a | 32'h1;
        if (r == 3) a = a | 32'h0010_0000 | (32'($urandom_range(0, 255)) << 24);
        run_single(port, we, a, $urandom, lat, "rand_single");
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_lat = 1;
    last_g = 1'b1;
    test_reset();
    test_tie_order();
    test_fetch_read();
    test_write();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
